// File: rtl/decoder_scan.sv
// Registered one-hot decoder with an auto-scanning mode: in scan mode the
// asserted output walks through all N positions, dwelling DWELL+1 cycles each.

module decoder_scan_lane #(
  parameter int SEL_W = 5,
  parameter int LANE  = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic             hit
);
  localparam logic [SEL_W-1:0] LANE_IDX = SEL_W'(LANE);

  assign hit = en && (sel == LANE_IDX);
endmodule

module decoder_scan #(
  parameter int SEL_W   = 5,
  parameter int DWELL_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  MODE,
  input  logic [SEL_W-1:0]      IN,
  input  logic                  LOAD,
  input  logic [DWELL_W-1:0]    DWELL,
  output logic [2**SEL_W-1:0]   OUT,
  output logic [SEL_W-1:0]      IDX,
  output logic                  WRAP
);
  localparam int               N       = 2**SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);

  typedef enum logic {S_DEC, S_SCAN} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic [N-1:0]         out_q, out_d;
  logic                 out_en;

  // OUT is always decoded from the next index, so it can only ever be
  // zero or the single bit matching IDX.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      S_DEC: begin
        cnt_d = '0;
        if (MODE) begin
          state_d = S_SCAN;
          out_en  = 1'b1;
        end else if (EN) begin
          idx_d  = IN;
          out_en = 1'b1;
        end
      end
      S_SCAN: begin
        if (!MODE) begin
          state_d = S_DEC;
          cnt_d   = '0;
          if (EN) begin
            idx_d  = IN;
            out_en = 1'b1;
          end
        end else if (LOAD) begin
          idx_d  = IN;
          cnt_d  = '0;
          out_en = 1'b1;
        end else if (EN) begin
          out_en = 1'b1;
          // Live DWELL compare: lowering it below the count forces an advance.
          if (cnt_q >= DWELL) begin
            cnt_d  = '0;
            idx_d  = idx_q + SEL_W'(1);
            wrap_d = (idx_q == IDX_MAX);
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end else begin
          out_en = 1'b1;
        end
      end
      default: begin
        state_d = S_DEC;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    decoder_scan_lane #(.SEL_W(SEL_W), .LANE(i)) u_lane (
      .sel (idx_d),
      .en  (out_en),
      .hit (out_d[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_DEC;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign OUT  = out_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;
endmodule
